// File: rtl/echo_timer.sv
// echo_timer: ultrasonic ranging front end. It fires a trigger pulse, times the
// returned echo in clk cycles and publishes a 23-bit result.
// Result encoding: 0 = no result yet, 1..2^23-2 = echo width,
// 23'h7FFFFF = no echo, out of range or saturated.
module echo_timer #(
  parameter int unsigned TRIG_CYCLES   = 1000,
  parameter int unsigned ECHO_WAIT_MAX = 3_000_000,
  parameter int unsigned COOLDOWN_CYC  = 6_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        echo_in,
  output logic        trig_out,
  output logic [22:0] data_output,
  output logic        data_valid
);

  localparam int unsigned DW = 23;
  localparam int unsigned TW = (TRIG_CYCLES  > 1) ? $clog2(TRIG_CYCLES)  : 1;
  localparam int unsigned CW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

  localparam logic [DW-1:0] SAT       = '1;
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [DW-1:0] WAIT_LAST = DW'(ECHO_WAIT_MAX - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIGGER   = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    COOLDOWN  = 3'd4
  } state_e;

  // Internal reset: asserts asynchronously, releases on the clock
  logic rst_meta_q;
  logic rst_sync_q;

  // Echo synchroniser and edge detect
  logic echo_meta_q;
  logic echo_s_q;
  logic echo_d3_q;
  logic rise_c;
  logic fall_c;

  // FSM and datapath
  state_e        state_q,     state_d;
  logic [TW-1:0] trig_cnt_q,  trig_cnt_d;
  logic [DW-1:0] wait_cnt_q,  wait_cnt_d;
  logic [DW-1:0] width_cnt_q, width_cnt_d;
  logic [CW-1:0] cool_cnt_q,  cool_cnt_d;
  logic          trig_q,      trig_d;
  logic [DW-1:0] data_q,      data_d;
  logic          valid_q,     valid_d;

  // Reset synchroniser: async assert, two-flop synchronous release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Two-flop echo synchroniser plus a third flop for edge strobes
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_d3_q   <= 1'b0;
    end else begin
      echo_meta_q <= echo_in;
      echo_s_q    <= echo_meta_q;
      echo_d3_q   <= echo_s_q;
    end
  end

  assign rise_c = echo_s_q & ~echo_d3_q;
  assign fall_c = ~echo_s_q & echo_d3_q;

  // State register
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; timeout beats a simultaneous rise, saturation beats a fall
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = TRIGGER;
      end
      TRIGGER: begin
        if (trig_cnt_q == TRIG_LAST) state_d = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = COOLDOWN;
        end else if (rise_c) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if ((width_cnt_q == SAT) || fall_c) state_d = COOLDOWN;
      end
      COOLDOWN: begin
        if (cool_cnt_q == COOL_LAST) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and counter next values; counters clear whenever their state is left
  always_comb begin
    trig_cnt_d  = '0;
    wait_cnt_d  = '0;
    width_cnt_d = '0;
    cool_cnt_d  = '0;
    trig_d      = (state_d == TRIGGER);
    data_d      = data_q;
    valid_d     = 1'b0;

    case (state_q)
      TRIGGER: begin
        if (state_d == TRIGGER) trig_cnt_d = trig_cnt_q + TW'(1);
      end
      WAIT_ECHO: begin
        if (state_d == WAIT_ECHO) wait_cnt_d = wait_cnt_q + DW'(1);
        if (state_d == MEASURE)   width_cnt_d = DW'(1);
      end
      MEASURE: begin
        if (state_d == MEASURE) begin
          width_cnt_d = width_cnt_q;
          if (echo_s_q && (width_cnt_q != SAT)) width_cnt_d = width_cnt_q + DW'(1);
        end
      end
      COOLDOWN: begin
        if (state_d == COOLDOWN) cool_cnt_d = cool_cnt_q + CW'(1);
      end
      default: begin
      end
    endcase

    // Publish a result on every entry into COOLDOWN
    if ((state_d == COOLDOWN) && (state_q != COOLDOWN)) begin
      valid_d = 1'b1;
      if ((state_q == MEASURE) && (width_cnt_q != SAT)) begin
        data_d = width_cnt_q;
      end else begin
        data_d = SAT;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      trig_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      width_cnt_q <= '0;
      cool_cnt_q  <= '0;
      trig_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      trig_cnt_q  <= trig_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      width_cnt_q <= width_cnt_d;
      cool_cnt_q  <= cool_cnt_d;
      trig_q      <= trig_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign trig_out    = trig_q;
  assign data_output = data_q;
  assign data_valid  = valid_q;

endmodule
